// File: rtl/seg_display_fmt.sv
// Signed 16-bit value to 8-digit active-low seven-segment codes.
// Magnitude goes through a 16-step double-dabble, then one cycle formats the digits.
module seg_display_fmt (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        err,
  output logic [7:0]  LED7,
  output logic [7:0]  LED6,
  output logic [7:0]  LED5,
  output logic [7:0]  LED4,
  output logic [7:0]  LED3,
  output logic [7:0]  LED2,
  output logic [7:0]  LED1,
  output logic [7:0]  LED0,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] FMT  = 2'd2;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  logic [1:0]  state_reg;
  logic [15:0] shift_reg;
  logic [19:0] bcd_reg;
  logic [4:0]  cnt_reg;
  logic        neg_reg;
  logic        err_reg;
  logic        done_reg;
  logic [7:0]  led_reg  [8];
  logic [7:0]  led_next [8];
  logic [19:0] bcd_adj;
  logic [2:0]  msd;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction on every BCD digit before the shift.
  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  // Index of the most significant nonzero digit; 0 when the magnitude is 0.
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 5; i++) begin
      if (bcd_reg[i*4 +: 4] != 4'd0) msd = 3'(i);
    end
  end

  generate
    for (gi = 0; gi < 8; gi++) begin : g_led
      if (gi < 5) begin : g_num
        localparam logic [7:0] ERR_CODE = (gi == 2) ? 8'h86 : ((gi < 2) ? 8'hAF : 8'hFF);
        always_comb begin
          if (err_reg)
            led_next[gi] = ERR_CODE;
          else if (3'(gi) <= msd)
            led_next[gi] = seg_code(bcd_reg[gi*4 +: 4]);
          else if (neg_reg && (3'(gi) == msd + 3'd1))
            led_next[gi] = SEG_MINUS;
          else
            led_next[gi] = SEG_BLANK;
        end
      end else if (gi == 5) begin : g_sign
        assign led_next[gi] = (!err_reg && neg_reg && msd == 3'd4) ? SEG_MINUS : SEG_BLANK;
      end else begin : g_blank
        assign led_next[gi] = SEG_BLANK;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      shift_reg <= 16'd0;
      bcd_reg   <= 20'd0;
      cnt_reg   <= 5'd0;
      neg_reg   <= 1'b0;
      err_reg   <= 1'b0;
      done_reg  <= 1'b0;
      for (int i = 0; i < 8; i++) led_reg[i] <= SEG_BLANK;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            err_reg   <= err;
            neg_reg   <= value[15];
            shift_reg <= value[15] ? (~value + 16'd1) : value;
            bcd_reg   <= 20'd0;
            cnt_reg   <= 5'd0;
            state_reg <= CONV;
          end
        end
        CONV: begin
          bcd_reg   <= {bcd_adj[18:0], shift_reg[15]};
          shift_reg <= {shift_reg[14:0], 1'b0};
          cnt_reg   <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd15) state_reg <= FMT;
        end
        FMT: begin
          for (int i = 0; i < 8; i++) led_reg[i] <= led_next[i];
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign LED0 = led_reg[0];
  assign LED1 = led_reg[1];
  assign LED2 = led_reg[2];
  assign LED3 = led_reg[3];
  assign LED4 = led_reg[4];
  assign LED5 = led_reg[5];
  assign LED6 = led_reg[6];
  assign LED7 = led_reg[7];
  assign busy = (state_reg != IDLE);
  assign done = done_reg;

endmodule

// File: tb/tb_seg_display_fmt.sv
// Randomised and directed checks of seg_display_fmt against a decimal-arithmetic display model.
module tb_seg_display_fmt;
  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] value;
  logic        err;
  logic [7:0]  LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  logic [7:0] led_obs  [8];
  logic [7:0] exp_led  [8];
  logic [7:0] prev_exp [8];
  logic [7:0] seg_tab  [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg_display_fmt dut (
    .clk(clk), .rst(rst), .start(start), .value(value), .err(err),
    .LED7(LED7), .LED6(LED6), .LED5(LED5), .LED4(LED4),
    .LED3(LED3), .LED2(LED2), .LED1(LED1), .LED0(LED0),
    .busy(busy), .done(done)
  );

  assign led_obs[0] = LED0;
  assign led_obs[1] = LED1;
  assign led_obs[2] = LED2;
  assign led_obs[3] = LED3;
  assign led_obs[4] = LED4;
  assign led_obs[5] = LED5;
  assign led_obs[6] = LED6;
  assign led_obs[7] = LED7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // Expected display: right-aligned decimal digits, minus just left of the top digit.
  task automatic model(input logic [15:0] v, input logic e);
    int m;
    int pos;
    bit neg;
    for (int i = 0; i < 8; i++) exp_led[i] = 8'hFF;
    if (e) begin
      exp_led[2] = 8'h86;
      exp_led[1] = 8'hAF;
      exp_led[0] = 8'hAF;
    end else begin
      m   = int'($signed(v));
      neg = (m < 0);
      if (neg) m = -m;
      pos = 0;
      do begin
        exp_led[pos] = seg_tab[m % 10];
        m = m / 10;
        pos++;
      end while (m > 0);
      if (neg) exp_led[pos] = 8'hBF;
    end
  endtask

  task automatic check_leds(input string tag, input bit use_prev);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_LED%0d", tag, i), 32'(led_obs[i]),
            32'(use_prev ? prev_exp[i] : exp_led[i]));
  endtask

  // Runs one conversion. With already=1 the caller has already raised start
  // for the coming edge; with chain=1 the task returns in the done cycle.
  task automatic do_conv(input string tag, input logic [15:0] v, input logic e,
                         input bit glitch, input bit chain, input bit already);
    int last;
    model(v, e);
    if (!already) begin
      @(negedge clk);
      start = 1'b1;
      value = v;
      err   = e;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    value = 16'($urandom);
    err   = 1'($urandom);
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    last = chain ? 17 : 18;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("%s_busy%0d", tag, n), 32'(busy), 32'(n < 17));
      check($sformatf("%s_done%0d", tag, n), 32'(done), 32'(n == 17));
      if (n == 8) check_leds({tag, "_hold"}, 1'b1);
      if (n == 17) begin
        check_leds(tag, 1'b0);
        for (int i = 0; i < 8; i++) prev_exp[i] = exp_led[i];
      end
      if (glitch && (n == 2 || n == 9)) begin
        start = 1'b1;
        value = 16'($urandom);
        err   = 1'($urandom);
      end
      if (glitch && (n == 3 || n == 10)) start = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] rv;
    logic        re;
    rst   = 1'b0;
    start = 1'b0;
    value = 16'd0;
    err   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      prev_exp[i] = 8'hFF;
      exp_led[i]  = 8'hFF;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_leds("rst", 1'b1);
    @(negedge clk);
    rst = 1'b1;

    do_conv("v1234", 16'd1234, 1'b0, 1'b0, 1'b0, 1'b0);
    do_conv("v0", 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_conv("vmin", 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
    do_conv("vm7", 16'hFFF9, 1'b0, 1'b0, 1'b0, 1'b0);
    do_conv("err55", 16'd55, 1'b1, 1'b0, 1'b0, 1'b0);
    do_conv("vmax", 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b0);
    do_conv("glitch", 16'd4321, 1'b0, 1'b1, 1'b0, 1'b0);

    // Start raised in the done cycle launches the next conversion at once.
    do_conv("chain_a", 16'hFF38, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    value = 16'd90;
    err   = 1'b0;
    do_conv("chain_b", 16'd90, 1'b0, 1'b0, 1'b0, 1'b1);

    for (int t = 0; t < 20; t++) begin
      rv = 16'($urandom);
      if (t % 4 == 1) rv = 16'($urandom_range(0, 99));
      if (t % 4 == 2) rv = -16'($urandom_range(1, 99));
      re = ($urandom_range(0, 7) == 0);
      do_conv($sformatf("rnd%0d", t), rv, re, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    start = 1'b1;
    value = 16'd999;
    err   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) prev_exp[i] = 8'hFF;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check_leds("arst", 1'b1);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      check($sformatf("arst_nodone%0d", n), 32'(done), 32'd0);
    end
    check_leds("arst_after", 1'b1);

    // Start accepted on the very first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    value = 16'hFED4;
    err   = 1'b0;
    do_conv("post_rst", 16'hFED4, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
